// File: rtl/fractal_pixel_scheduler_if.sv
// Engine-array and pixel-stream signals of the fractal pixel scheduler.
// The master side is the scheduler; the slave side is the engine array and the pixel consumer.
interface fractal_pixel_scheduler_if #(
  parameter int NUM_ENGINES = 4,
  parameter int ITER_WIDTH  = 6,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10
);
  logic                            enable;
  logic                            frame_start;
  logic [NUM_ENGINES-1:0]          eng_start;
  logic [NUM_ENGINES*X_WIDTH-1:0]  eng_x;
  logic [NUM_ENGINES*Y_WIDTH-1:0]  eng_y;
  logic [NUM_ENGINES-1:0]          eng_done;
  logic [NUM_ENGINES*ITER_WIDTH-1:0] eng_iter;
  logic                            pix_valid;
  logic                            pix_ready;
  logic [ITER_WIDTH-1:0]           pix_iter;
  logic                            pix_eol;
  logic                            pix_eof;
  logic                            frame_done;

  modport master (
    input  enable, frame_start, eng_done, eng_iter, pix_ready,
    output eng_start, eng_x, eng_y, pix_valid, pix_iter, pix_eol, pix_eof, frame_done
  );

  modport slave (
    output enable, frame_start, eng_done, eng_iter, pix_ready,
    input  eng_start, eng_x, eng_y, pix_valid, pix_iter, pix_eol, pix_eof, frame_done
  );
endinterface

// File: rtl/fractal_pixel_scheduler.sv
// Dispatches raster coordinates to parallel Mandelbrot engines and returns their
// results in strict raster order through a DEPTH-slot reorder ring.
module fractal_pixel_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int ITER_WIDTH  = 6,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int DEPTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  fractal_pixel_scheduler_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [X_WIDTH-1:0] X_LAST     = X_WIDTH'(H_ACTIVE - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST     = Y_WIDTH'(V_ACTIVE - 1);
  localparam logic [PW-1:0]      RING_SLOTS = PW'(DEPTH);

  // Raster generator and frame epoch
  logic [X_WIDTH-1:0] gx_q, gx_d;
  logic [Y_WIDTH-1:0] gy_q, gy_d;
  logic               gen_done_q, gen_done_d;
  logic               epoch_q, epoch_d;

  // Reorder ring
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]      filled_q, filled_d;
  logic [DEPTH-1:0]      eol_q, eol_d, eof_q, eof_d;
  logic [ITER_WIDTH-1:0] iter_q [DEPTH];
  logic [ITER_WIDTH-1:0] iter_d [DEPTH];

  // Per-engine bookkeeping
  logic [NUM_ENGINES-1:0] busy_q, busy_d;
  logic [NUM_ENGINES-1:0] etag_q, etag_d;
  logic [NUM_ENGINES-1:0] start_q, start_d;
  logic [AW-1:0]          stag_q [NUM_ENGINES];
  logic [AW-1:0]          stag_d [NUM_ENGINES];
  logic [X_WIDTH-1:0]     ex_q   [NUM_ENGINES];
  logic [X_WIDTH-1:0]     ex_d   [NUM_ENGINES];
  logic [Y_WIDTH-1:0]     ey_q   [NUM_ENGINES];
  logic [Y_WIDTH-1:0]     ey_d   [NUM_ENGINES];

  // Registered pixel-stream outputs
  logic                  pix_valid_q, pix_valid_d;
  logic [ITER_WIDTH-1:0] pix_iter_q, pix_iter_d;
  logic                  pix_eol_q, pix_eol_d;
  logic                  pix_eof_q, pix_eof_d;
  logic                  frame_done_q, frame_done_d;

  logic                   free_found;
  logic [EW-1:0]          free_idx;
  logic [PW-1:0]          occupancy;
  logic                   dispatch;
  logic                   pop;
  logic [AW-1:0]          hidx;
  logic [NUM_ENGINES-1:0] live_busy;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      if (!free_found && !busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = EW'(i);
      end
    end
  end

  assign occupancy = tail_q - head_q;
  assign dispatch  = bus.enable && !gen_done_q && !bus.frame_start && free_found &&
                     (occupancy < RING_SLOTS);
  assign pop       = !bus.frame_start && pix_valid_q && bus.pix_ready;

  always_comb begin
    gx_d       = gx_q;
    gy_d       = gy_q;
    gen_done_d = gen_done_q;
    epoch_d    = epoch_q;
    head_d     = head_q;
    tail_d     = tail_q;
    filled_d   = filled_q;
    eol_d      = eol_q;
    eof_d      = eof_q;
    iter_d     = iter_q;
    busy_d     = busy_q;
    etag_d     = etag_q;
    stag_d     = stag_q;
    ex_d       = ex_q;
    ey_d       = ey_q;
    start_d    = '0;

    // A done coinciding with frame_start belongs to the old frame and only frees the engine.
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      if (bus.eng_done[i] && busy_q[i]) begin
        busy_d[i] = 1'b0;
        if (!bus.frame_start && (etag_q[i] == epoch_q)) begin
          filled_d[stag_q[i]] = 1'b1;
          iter_d[stag_q[i]]   = bus.eng_iter[i*ITER_WIDTH +: ITER_WIDTH];
        end
      end
    end

    if (pop) begin
      filled_d[head_q[AW-1:0]] = 1'b0;
      head_d                   = head_q + PW'(1);
    end

    if (dispatch) begin
      busy_d[free_idx]         = 1'b1;
      etag_d[free_idx]         = epoch_q;
      stag_d[free_idx]         = tail_q[AW-1:0];
      ex_d[free_idx]           = gx_q;
      ey_d[free_idx]           = gy_q;
      start_d[free_idx]        = 1'b1;
      filled_d[tail_q[AW-1:0]] = 1'b0;
      eol_d[tail_q[AW-1:0]]    = (gx_q == X_LAST);
      eof_d[tail_q[AW-1:0]]    = (gx_q == X_LAST) && (gy_q == Y_LAST);
      tail_d                   = tail_q + PW'(1);
      if (gx_q == X_LAST) begin
        gx_d = '0;
        if (gy_q == Y_LAST) begin
          gen_done_d = 1'b1;
        end else begin
          gy_d = gy_q + Y_WIDTH'(1);
        end
      end else begin
        gx_d = gx_q + X_WIDTH'(1);
      end
    end

    if (bus.frame_start) begin
      head_d     = tail_q;
      filled_d   = '0;
      gx_d       = '0;
      gy_d       = '0;
      gen_done_d = 1'b0;
      epoch_d    = ~epoch_q;
    end
  end

  // Outputs are registered from next state so a head slot filled at edge N shows at N+1.
  always_comb begin
    hidx         = head_d[AW-1:0];
    pix_valid_d  = filled_d[hidx] && (head_d != tail_d);
    pix_iter_d   = iter_d[hidx];
    pix_eol_d    = eol_d[hidx];
    pix_eof_d    = eof_d[hidx];
    live_busy    = busy_d & ~(etag_d ^ {NUM_ENGINES{epoch_d}});
    frame_done_d = gen_done_d && (head_d == tail_d) && (live_busy == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx_q         <= '0;
      gy_q         <= '0;
      gen_done_q   <= 1'b0;
      epoch_q      <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      filled_q     <= '0;
      eol_q        <= '0;
      eof_q        <= '0;
      busy_q       <= '0;
      etag_q       <= '0;
      start_q      <= '0;
      pix_valid_q  <= 1'b0;
      pix_iter_q   <= '0;
      pix_eol_q    <= 1'b0;
      pix_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        iter_q[s] <= '0;
      end
      for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
        stag_q[i] <= '0;
        ex_q[i]   <= '0;
        ey_q[i]   <= '0;
      end
    end else begin
      gx_q         <= gx_d;
      gy_q         <= gy_d;
      gen_done_q   <= gen_done_d;
      epoch_q      <= epoch_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      filled_q     <= filled_d;
      eol_q        <= eol_d;
      eof_q        <= eof_d;
      iter_q       <= iter_d;
      busy_q       <= busy_d;
      etag_q       <= etag_d;
      stag_q       <= stag_d;
      ex_q         <= ex_d;
      ey_q         <= ey_d;
      start_q      <= start_d;
      pix_valid_q  <= pix_valid_d;
      pix_iter_q   <= pix_iter_d;
      pix_eol_q    <= pix_eol_d;
      pix_eof_q    <= pix_eof_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.eng_start  = start_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_iter   = pix_iter_q;
  assign bus.pix_eol    = pix_eol_q;
  assign bus.pix_eof    = pix_eof_q;
  assign bus.frame_done = frame_done_q;

  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_coord
    assign bus.eng_x[g*X_WIDTH +: X_WIDTH] = ex_q[g];
    assign bus.eng_y[g*Y_WIDTH +: Y_WIDTH] = ey_q[g];
  end
endmodule

// File: tb/tb_fractal_pixel_scheduler.sv
// Directed bench for fractal_pixel_scheduler on a reduced 8x4 raster with a
// behavioural engine array and an in-order pixel scoreboard.
module tb_fractal_pixel_scheduler;
  localparam int NE   = 4;
  localparam int IW   = 6;
  localparam int XW   = 10;
  localparam int YW   = 10;
  localparam int H    = 8;
  localparam int V    = 4;
  localparam int D    = 16;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fractal_pixel_scheduler_if #(.NUM_ENGINES(NE), .ITER_WIDTH(IW), .X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

  fractal_pixel_scheduler #(
    .NUM_ENGINES(NE), .ITER_WIDTH(IW), .X_WIDTH(XW), .Y_WIDTH(YW),
    .H_ACTIVE(H), .V_ACTIVE(V), .DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string name;
    int    lat_min;
    int    lat_max;
    bit    ready_rand;
    int    exp_beats;
    int    exp_eol;
    int    exp_eof;
  } vec_t;

  vec_t vecs[4];

  int tests = 0;
  int fails = 0;

  // engine model state
  bit act[NE];
  int cnt[NE];
  int mx[NE];
  int my[NE];
  int done_cyc[NE];
  int lat_min = 5, lat_max = 5;
  bit lat_pair = 1'b0;
  bit ready_rand = 1'b0;
  bit ready_hold = 1'b0;

  // scoreboard state
  int exp_disp = 0, exp_beat = 0, n_eol = 0, n_eof = 0, n_start = 0;
  int first_eng = -1;
  int cyc = 0;
  int beat_cyc[2];

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int active_count();
    int n = 0;
    for (int i = 0; i < NE; i++) n += int'(act[i]);
    return n;
  endfunction

  task automatic step(input bit fs = 1'b0);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NE; i++) begin
      bus.eng_done[i] = 1'b0;
      if (act[i]) begin
        cnt[i]--;
        if (cnt[i] <= 0) begin
          check("busy_x_held", int'(bus.eng_x[i*XW +: XW]), mx[i]);
          bus.eng_done[i]          = 1'b1;
          bus.eng_iter[i*IW +: IW] = IW'(my[i] * H + mx[i]);
          done_cyc[i]              = cyc;
          act[i]                   = 1'b0;
        end
      end
      if (bus.eng_start[i]) begin
        check("start_on_idle", int'(act[i]), 0);
        mx[i] = int'(bus.eng_x[i*XW +: XW]);
        my[i] = int'(bus.eng_y[i*YW +: YW]);
        check("disp_x", mx[i], exp_disp % H);
        check("disp_y", my[i], exp_disp / H);
        if (n_start == 0) first_eng = i;
        exp_disp++;
        n_start++;
        act[i] = 1'b1;
        cnt[i] = lat_pair ? ((i == 0) ? 2 : 1) : int'($urandom_range(lat_max, lat_min));
      end
    end
    bus.frame_start = fs;
    if (fs) begin
      exp_disp = 0; exp_beat = 0; n_eol = 0; n_eof = 0; n_start = 0; first_eng = -1;
    end
    bus.pix_ready = (fs || ready_hold) ? 1'b0 : (ready_rand ? (($urandom % 2) == 1) : 1'b1);
    if (bus.pix_valid && bus.pix_ready) begin
      check("pix_iter", int'(bus.pix_iter), exp_beat % 64);
      check("pix_eol", int'(bus.pix_eol), int'((exp_beat % H) == H - 1));
      check("pix_eof", int'(bus.pix_eof), int'(exp_beat == NPIX - 1));
      if (bus.pix_eol) n_eol++;
      if (bus.pix_eof) n_eof++;
      if (exp_beat < 2) beat_cyc[exp_beat] = cyc;
      exp_beat++;
    end
  endtask

  task automatic run_frame(input string name, input int beats, input int eols, input int eofs);
    int guard;
    step();
    check({name, "_frame_done_early"}, int'(bus.frame_done), 0);
    guard = 0;
    while (exp_beat < NPIX && guard < 3000) begin
      step();
      guard++;
    end
    guard = 0;
    while (!bus.frame_done && guard < 50) begin
      step();
      guard++;
    end
    check({name, "_beats"}, exp_beat, beats);
    check({name, "_eol_count"}, n_eol, eols);
    check({name, "_eof_count"}, n_eof, eofs);
    check({name, "_frame_done"}, int'(bus.frame_done), 1);
  endtask

  initial begin
    int guard;
    int m;

    vecs[0] = '{"fixed5",   5,  5,  1'b0, NPIX, V, 1};
    vecs[1] = '{"rand1_40", 1,  40, 1'b0, NPIX, V, 1};
    vecs[2] = '{"rand_rdy", 1,  10, 1'b1, NPIX, V, 1};
    vecs[3] = '{"lat1",     1,  1,  1'b0, NPIX, V, 1};

    rst             = 1'b0;
    bus.enable      = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_ready   = 1'b0;
    bus.eng_done    = '0;
    bus.eng_iter    = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_eng_start", int'(bus.eng_start), 0);
    check("rst_eng_x_zero", int'(bus.eng_x == '0), 1);
    check("rst_eng_y_zero", int'(bus.eng_y == '0), 1);
    check("rst_pix_valid", int'(bus.pix_valid), 0);
    check("rst_pix_iter", int'(bus.pix_iter), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    rst = 1'b0;

    // done pulses on idle engines must not produce pixels
    step();
    bus.eng_done = '1;
    bus.eng_iter = '1;
    step();
    step();
    check("idle_done_pix_valid", int'(bus.pix_valid), 0);
    check("idle_done_starts", n_start, 0);

    bus.enable = 1'b1;
    for (int v = 0; v < 4; v++) begin
      lat_min    = vecs[v].lat_min;
      lat_max    = vecs[v].lat_max;
      ready_rand = vecs[v].ready_rand;
      step(1'b1);
      run_frame(vecs[v].name, vecs[v].exp_beats, vecs[v].exp_eol, vecs[v].exp_eof);
    end
    ready_rand = 1'b0;

    // consumer stalled: ring fills to DEPTH and dispatch stops
    lat_min = 3; lat_max = 3;
    ready_hold = 1'b1;
    step(1'b1);
    repeat (100) step();
    check("bp_dispatches", n_start, D);
    check("bp_beats", exp_beat, 0);
    check("bp_pix_valid", int'(bus.pix_valid), 1);
    ready_hold = 1'b0;
    run_frame("bp", NPIX, V, 1);

    // restart while three engines hold old-frame work
    lat_min = 20; lat_max = 20;
    step(1'b1);
    guard = 0;
    while (active_count() < 2 && guard < 20) begin
      step();
      guard++;
    end
    step(1'b1);
    check("stale_busy3", active_count(), 3);
    run_frame("stale", NPIX, V, 1);
    check("stale_first_engine", first_eng, 3);

    // simultaneous completion of the first two slots
    lat_pair = 1'b1;
    step(1'b1);
    guard = 0;
    while (exp_beat < 2 && guard < 30) begin
      step();
      guard++;
    end
    check("pair_done_same_cycle", done_cyc[1], done_cyc[0]);
    check("pair_head_latency", beat_cyc[0], done_cyc[0] + 1);
    check("pair_consecutive", beat_cyc[1], beat_cyc[0] + 1);
    run_frame("pair", NPIX, V, 1);
    lat_pair = 1'b0;

    // enable dropped mid-frame: no new starts, in-flight work drains
    lat_min = 4; lat_max = 4;
    step(1'b1);
    guard = 0;
    while (exp_beat < 5 && guard < 100) begin
      step();
      guard++;
    end
    bus.enable = 1'b0;
    step();
    m = n_start;
    repeat (40) step();
    check("en_gap_starts", n_start, m);
    check("en_gap_drained", active_count(), 0);
    check("en_gap_beats", exp_beat, m);
    bus.enable = 1'b1;
    run_frame("en_gap", NPIX, V, 1);

    // asynchronous reset mid-frame
    lat_min = 6; lat_max = 6;
    step(1'b1);
    guard = 0;
    while (exp_beat < 3 && guard < 100) begin
      step();
      guard++;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_pix_valid", int'(bus.pix_valid), 0);
    check("arst_eng_start", int'(bus.eng_start), 0);
    check("arst_frame_done", int'(bus.frame_done), 0);
    for (int i = 0; i < NE; i++) act[i] = 1'b0;
    bus.eng_done = '0;
    exp_disp = 0; exp_beat = 0; n_eol = 0; n_eof = 0; n_start = 0; first_eng = -1;
    @(negedge clk);
    rst = 1'b0;
    run_frame("post_rst", NPIX, V, 1);
    check("post_rst_first_engine", first_eng, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
